// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared types for the MD position-read path.
//   particle_id_t  : particle index / particle count width
//   NUM_FILTER     : number of downstream filters fed by the read path
//   seq_state_t    : pos_read_sequencer FSM encoding, exported so monitors
//                    can decode the state register
// -----------------------------------------------------------------------------
package md_pkg;

  localparam int PARTICLE_ID_W = 8;
  localparam int NUM_FILTER    = 8;

  typedef logic [PARTICLE_ID_W-1:0] particle_id_t;

  localparam particle_id_t PID_ZERO = {PARTICLE_ID_W{1'b0}};
  localparam particle_id_t PID_ONE  = {{(PARTICLE_ID_W-1){1'b0}}, 1'b1};

  // Legacy-compatible raw encodings; the enum below reuses them.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_READ_NUM  = 3'd1;
  localparam logic [2:0] ST_WAIT_CNT  = 3'd2;
  localparam logic [2:0] ST_BCAST     = 3'd3;
  localparam logic [2:0] ST_NEXT_REF  = 3'd4;
  localparam logic [2:0] ST_PHASE_END = 3'd5;
  localparam logic [2:0] ST_FINISH    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_READ_NUM  = ST_READ_NUM,
    S_WAIT_CNT  = ST_WAIT_CNT,
    S_BCAST     = ST_BCAST,
    S_NEXT_REF  = ST_NEXT_REF,
    S_PHASE_END = ST_PHASE_END,
    S_FINISH    = ST_FINISH
  } seq_state_t;

  // True once the incremented reference index has walked past the last
  // home-cell particle. ref_next carries one extra bit so a full cell
  // cannot wrap the comparison.
  function automatic logic ref_exhausted(input logic [PARTICLE_ID_W:0] ref_next,
                                         input particle_id_t             home_cnt);
    return (ref_next > {1'b0, home_cnt});
  endfunction

endpackage

// File: rtl/pos_read_sequencer.sv
// -----------------------------------------------------------------------------
// pos_read_sequencer
// Walks one cell pass of the position memory: reads the cell header, waits for
// the home particle count, then for every half-shell phase broadcasts each
// home (reference) particle against neighbour indices 1..nb_max_count.
//
// Parameters
//   COUNT_WAIT   idle cycles after the header read before home_count is valid
//   NUM_PHASES   half-shell phases per cell pass
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    one-cycle pulse, accepted only while idle
//   pause_req                downstream filter buffers almost full
//   home_count               home-cell particle count from the preprocessor
//   nb_max_count             largest neighbour-cell count for current phase
//   phase                    current half-shell phase
//   reading_particle_num     cell-header read strobe
//   pause_reading            pause_req delayed one cycle; freezes the walk
//   ref_id, particle_id      reference / neighbour particle indices
//   rd_en                    position memory read enable
//   busy, done               activity flag and one-cycle end-of-pass pulse
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module pos_read_sequencer
  import md_pkg::*;
#(
  parameter int unsigned COUNT_WAIT = 2,
  parameter int unsigned NUM_PHASES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         pause_req,
  input  particle_id_t home_count,
  input  particle_id_t nb_max_count,
  output logic         phase,
  output logic         reading_particle_num,
  output logic         pause_reading,
  output particle_id_t ref_id,
  output particle_id_t particle_id,
  output logic         rd_en,
  output logic         busy,
  output logic         done
);

  localparam int WCNT_W = (COUNT_WAIT < 2) ? 1 : $clog2(COUNT_WAIT + 1);

  seq_state_t          state_q, state_d;
  logic                phase_q, phase_d;
  particle_id_t        ref_q, ref_d;
  particle_id_t        pid_q, pid_d;
  particle_id_t        home_q, home_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                pause_q;
  logic                rnum_q;
  logic                rd_en_q;
  logic                busy_q;
  logic                done_q;

  logic                hold_s;
  logic                wait_last_s;
  logic                phase_last_s;
  logic [PARTICLE_ID_W:0] ref_inc_s;
  seq_state_t          after_ref_s;

  // IDLE and FINISH never stall so a pass can always be launched and closed.
  assign hold_s       = pause_q && (state_q != S_IDLE) && (state_q != S_FINISH);
  assign wait_last_s  = ((32'(wcnt_q) + 32'd1) >= COUNT_WAIT);
  assign phase_last_s = (NUM_PHASES <= 32'd1) || (32'(phase_q) >= (NUM_PHASES - 32'd1));
  assign ref_inc_s    = {1'b0, ref_q} + {{PARTICLE_ID_W{1'b0}}, 1'b1};
  // An empty neighbour set skips the broadcast state entirely.
  assign after_ref_s  = (nb_max_count == PID_ZERO) ? S_NEXT_REF : S_BCAST;

  // Next-state and counter update logic.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    ref_d   = ref_q;
    pid_d   = pid_q;
    home_d  = home_q;
    wcnt_d  = wcnt_q;

    if (hold_s) begin
      state_d = state_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_READ_NUM;
            phase_d = 1'b0;
            ref_d   = PID_ZERO;
            pid_d   = PID_ZERO;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_READ_NUM: begin
          state_d = S_WAIT_CNT;
          wcnt_d  = {WCNT_W{1'b0}};
        end

        S_WAIT_CNT: begin
          if (wait_last_s) begin
            // The header count is only fetched in phase 0; later phases
            // reuse the latched copy.
            if (!phase_q && (home_count == PID_ZERO)) begin
              home_d  = home_count;
              state_d = S_FINISH;
            end else begin
              if (!phase_q) begin
                home_d = home_count;
              end else begin
                home_d = home_q;
              end
              ref_d   = PID_ONE;
              pid_d   = PID_ONE;
              state_d = after_ref_s;
            end
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end

        S_BCAST: begin
          // >= rather than == so a shrinking nb_max_count can never strand
          // the walk above the limit.
          if (pid_q >= nb_max_count) begin
            state_d = S_NEXT_REF;
          end else begin
            pid_d = pid_q + PID_ONE;
          end
        end

        S_NEXT_REF: begin
          pid_d = PID_ONE;
          if (ref_inc_s[PARTICLE_ID_W]) begin
            ref_d = ref_q;
          end else begin
            ref_d = ref_inc_s[PARTICLE_ID_W-1:0];
          end
          if (ref_exhausted(ref_inc_s, home_q)) begin
            state_d = S_PHASE_END;
          end else begin
            state_d = after_ref_s;
          end
        end

        S_PHASE_END: begin
          if (!phase_last_s) begin
            phase_d = ~phase_q;
            ref_d   = PID_ZERO;
            pid_d   = PID_ZERO;
            state_d = S_READ_NUM;
          end else begin
            state_d = S_FINISH;
          end
        end

        S_FINISH: begin
          state_d = S_IDLE;
          phase_d = 1'b0;
          ref_d   = PID_ZERO;
          pid_d   = PID_ZERO;
        end

        default: begin
          state_d = S_IDLE;
          phase_d = 1'b0;
          ref_d   = PID_ZERO;
          pid_d   = PID_ZERO;
        end
      endcase
    end
  end

  // State, counters and registered outputs. Strobes are derived from the
  // next state so they line up with the registered state; read strobes use
  // pause_req because it becomes pause_reading on this same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      ref_q   <= PID_ZERO;
      pid_q   <= PID_ZERO;
      home_q  <= PID_ZERO;
      wcnt_q  <= {WCNT_W{1'b0}};
      pause_q <= 1'b0;
      rnum_q  <= 1'b0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      ref_q   <= ref_d;
      pid_q   <= pid_d;
      home_q  <= home_d;
      wcnt_q  <= wcnt_d;
      pause_q <= pause_req;
      rnum_q  <= (state_d == S_READ_NUM) && !pause_req;
      rd_en_q <= ((state_d == S_READ_NUM) || (state_d == S_BCAST)) && !pause_req;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_FINISH);
    end
  end

  assign phase                = phase_q;
  assign reading_particle_num = rnum_q;
  assign pause_reading        = pause_q;
  assign ref_id               = ref_q;
  assign particle_id          = pid_q;
  assign rd_en                = rd_en_q;
  assign busy                 = busy_q;
  assign done                 = done_q;

endmodule

// File: tb/tb_pos_read_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pos_read_sequencer
// Directed self-checking bench for pos_read_sequencer (COUNT_WAIT=2,
// NUM_PHASES=2). Each scenario compares a packed output vector per cycle
// against a hand-written expected trace:
//   {phase, reading_particle_num, pause_reading, ref_id, particle_id,
//    rd_en, busy, done}
// -----------------------------------------------------------------------------
module tb_pos_read_sequencer;
  import md_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         pause_req;
  particle_id_t home_count;
  particle_id_t nb_max_count;
  logic         phase;
  logic         reading_particle_num;
  logic         pause_reading;
  particle_id_t ref_id;
  particle_id_t particle_id;
  logic         rd_en;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pos_read_sequencer #(.COUNT_WAIT(2), .NUM_PHASES(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .pause_req            (pause_req),
    .home_count           (home_count),
    .nb_max_count         (nb_max_count),
    .phase                (phase),
    .reading_particle_num (reading_particle_num),
    .pause_reading        (pause_reading),
    .ref_id               (ref_id),
    .particle_id          (particle_id),
    .rd_en                (rd_en),
    .busy                 (busy),
    .done                 (done)
  );

  function automatic logic [21:0] v(input logic ph, input logic rn, input logic pr,
                                    input int r, input int p,
                                    input logic rd, input logic bz, input logic dn);
    return {ph, rn, pr, 8'(r), 8'(p), rd, bz, dn};
  endfunction

  function automatic logic [21:0] obs();
    return {phase, reading_particle_num, pause_reading, ref_id, particle_id, rd_en, busy, done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pause_req = 1'b0;
    home_count = 8'd0; nb_max_count = 8'd0;
    tick(); tick();
    n_cmp++; if (phase !== 1'b0) begin n_err++; $display("FAIL reset_phase got %b want 0", phase); end
    n_cmp++; if (reading_particle_num !== 1'b0) begin n_err++; $display("FAIL reset_rnum got %b want 0", reading_particle_num); end
    n_cmp++; if (pause_reading !== 1'b0) begin n_err++; $display("FAIL reset_pause got %b want 0", pause_reading); end
    n_cmp++; if (ref_id !== 8'd0) begin n_err++; $display("FAIL reset_ref got %0d want 0", ref_id); end
    n_cmp++; if (particle_id !== 8'd0) begin n_err++; $display("FAIL reset_pid got %0d want 0", particle_id); end
    n_cmp++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  // home=3, nb=2: 13 cycles per phase, FINISH at cycle 27 (26 cycles between
  // the start cycle and the done cycle).
  task automatic test_nominal();
    logic [21:0] exp_q[$];
    int first_done = 0;
    int done_cnt = 0;
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(v(p[0], 1, 0, 0, 0, 1, 1, 0));
      exp_q.push_back(v(p[0], 0, 0, 0, 0, 0, 1, 0));
      exp_q.push_back(v(p[0], 0, 0, 0, 0, 0, 1, 0));
      for (int r = 1; r <= 3; r++) begin
        exp_q.push_back(v(p[0], 0, 0, r, 1, 1, 1, 0));
        exp_q.push_back(v(p[0], 0, 0, r, 2, 1, 1, 0));
        exp_q.push_back(v(p[0], 0, 0, r, 2, 0, 1, 0));
      end
      exp_q.push_back(v(p[0], 0, 0, 4, 1, 0, 1, 0));
    end
    exp_q.push_back(v(1, 0, 0, 4, 1, 0, 1, 1));
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));
    home_count = 8'd3; nb_max_count = 8'd2;
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs() !== exp_q[i]) begin
        n_err++;
        $display("FAIL nominal cycle %0d got %h want %h", i + 1, obs(), exp_q[i]);
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = i + 1;
      end
      tick();
    end
    n_cmp++; if (first_done !== 27) begin n_err++; $display("FAIL nominal_latency got %0d want 27", first_done); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL nominal_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_empty_cell();
    logic [21:0] exp_q[$];
    exp_q.push_back(v(0, 1, 0, 0, 0, 1, 1, 0));
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 1, 0));
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 1, 0));
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 1, 1));
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));
    home_count = 8'd0; nb_max_count = 8'd2;
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs() !== exp_q[i]) begin
        n_err++;
        $display("FAIL empty_cell cycle %0d got %h want %h", i + 1, obs(), exp_q[i]);
      end
      tick();
    end
  endtask

  // home=1, nb=3, pause_req high in cycles 4..7 while particle_id=1.
  task automatic test_pause();
    logic [21:0] exp_q[$];
    exp_q.push_back(v(0, 1, 0, 0, 0, 1, 1, 0));
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 1, 0));
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 1, 0));
    exp_q.push_back(v(0, 0, 0, 1, 1, 1, 1, 0));
    for (int k = 0; k < 4; k++) exp_q.push_back(v(0, 0, 1, 1, 2, 0, 1, 0));
    exp_q.push_back(v(0, 0, 0, 1, 2, 1, 1, 0));
    exp_q.push_back(v(0, 0, 0, 1, 3, 1, 1, 0));
    exp_q.push_back(v(0, 0, 0, 1, 3, 0, 1, 0));
    exp_q.push_back(v(0, 0, 0, 2, 1, 0, 1, 0));
    exp_q.push_back(v(1, 1, 0, 0, 0, 1, 1, 0));
    exp_q.push_back(v(1, 0, 0, 0, 0, 0, 1, 0));
    exp_q.push_back(v(1, 0, 0, 0, 0, 0, 1, 0));
    exp_q.push_back(v(1, 0, 0, 1, 1, 1, 1, 0));
    exp_q.push_back(v(1, 0, 0, 1, 2, 1, 1, 0));
    exp_q.push_back(v(1, 0, 0, 1, 3, 1, 1, 0));
    exp_q.push_back(v(1, 0, 0, 1, 3, 0, 1, 0));
    exp_q.push_back(v(1, 0, 0, 2, 1, 0, 1, 0));
    exp_q.push_back(v(1, 0, 0, 2, 1, 0, 1, 1));
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));
    home_count = 8'd1; nb_max_count = 8'd3;
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs() !== exp_q[i]) begin
        n_err++;
        $display("FAIL pause cycle %0d got %h want %h", i + 1, obs(), exp_q[i]);
      end
      pause_req = ((i + 1) >= 4) && ((i + 1) <= 7);
      tick();
    end
    pause_req = 1'b0;
  endtask

  task automatic test_reset_mid_pass();
    bit seen_done = 1'b0;
    home_count = 8'd3; nb_max_count = 8'd2;
    pulse_start();
    for (int k = 0; k < 16; k++) tick();
    n_cmp++;
    if ({phase, rd_en, particle_id} !== {1'b1, 1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL midpass_pre got ph=%b rd=%b pid=%0d want ph=1 rd=1 pid=1", phase, rd_en, particle_id);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 22'd0) begin n_err++; $display("FAIL midpass_async_clear got %h want 0", obs()); end
    @(negedge clk); rst = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL midpass_no_resume got busy=%b want 0", busy); end
    pulse_start();
    n_cmp++;
    if (obs() !== v(0, 1, 0, 0, 0, 1, 1, 0)) begin
      n_err++;
      $display("FAIL midpass_restart got %h want %h", obs(), v(0, 1, 0, 0, 0, 1, 1, 0));
    end
    for (int k = 0; k < 60 && !seen_done; k++) begin
      if (done === 1'b1) seen_done = 1'b1;
      tick();
    end
    n_cmp++;
    if (!seen_done) begin n_err++; $display("FAIL midpass_done_timeout got no done want done within 60 cycles"); end
    tick();
  endtask

  // home=1, nb=3, extra start pulses at cycles 5 and 12 (both BCAST).
  task automatic test_start_while_busy();
    logic [21:0] exp_q[$];
    int done_cnt = 0;
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(v(p[0], 1, 0, 0, 0, 1, 1, 0));
      exp_q.push_back(v(p[0], 0, 0, 0, 0, 0, 1, 0));
      exp_q.push_back(v(p[0], 0, 0, 0, 0, 0, 1, 0));
      for (int q = 1; q <= 3; q++) exp_q.push_back(v(p[0], 0, 0, 1, q, 1, 1, 0));
      exp_q.push_back(v(p[0], 0, 0, 1, 3, 0, 1, 0));
      exp_q.push_back(v(p[0], 0, 0, 2, 1, 0, 1, 0));
    end
    exp_q.push_back(v(1, 0, 0, 2, 1, 0, 1, 1));
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));
    home_count = 8'd1; nb_max_count = 8'd3;
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs() !== exp_q[i]) begin
        n_err++;
        $display("FAIL start_busy cycle %0d got %h want %h", i + 1, obs(), exp_q[i]);
      end
      if (done === 1'b1) done_cnt++;
      start = ((i + 1) == 5) || ((i + 1) == 12);
      tick();
    end
    start = 1'b0;
    n_cmp++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL start_busy_done_count got %0d want 1", done_cnt); end
  endtask

  // home=2, nb=0: each ref goes straight through NEXT_REF, ref_id ends at 3.
  task automatic test_zero_neighbours();
    logic [21:0] exp_q[$];
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(v(p[0], 1, 0, 0, 0, 1, 1, 0));
      exp_q.push_back(v(p[0], 0, 0, 0, 0, 0, 1, 0));
      exp_q.push_back(v(p[0], 0, 0, 0, 0, 0, 1, 0));
      exp_q.push_back(v(p[0], 0, 0, 1, 1, 0, 1, 0));
      exp_q.push_back(v(p[0], 0, 0, 2, 1, 0, 1, 0));
      exp_q.push_back(v(p[0], 0, 0, 3, 1, 0, 1, 0));
    end
    exp_q.push_back(v(1, 0, 0, 3, 1, 0, 1, 1));
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));
    home_count = 8'd2; nb_max_count = 8'd0;
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs() !== exp_q[i]) begin
        n_err++;
        $display("FAIL zero_nb cycle %0d got %h want %h", i + 1, obs(), exp_q[i]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_empty_cell();
    test_pause();
    test_reset_mid_pass();
    test_start_while_busy();
    test_zero_neighbours();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
